// File: rtl/mul_norm_pipe.sv
// Two-stage leading-zero/leading-one counter and left normaliser.
// S1 registers the (optionally inverted) operand; S2 registers the count, all-same flag and shifted mantissa.
module mul_norm_pipe #(
    parameter int INPUT_WIDTH = 48,
    parameter int TAG_WIDTH   = 4,
    localparam int CNT_WIDTH  = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_lead_sel,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_WIDTH-1:0]   out_zero_nums,
    output logic                   out_all_same,
    output logic [INPUT_WIDTH-1:0] out_norm,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int LOGP = $clog2(INPUT_WIDTH);
    localparam int PW   = 1 << LOGP;
    localparam int TW   = LOGP + 1;

    logic                   en;
    logic                   s1_valid;
    logic [INPUT_WIDTH-1:0] s1_x;
    logic [INPUT_WIDTH-1:0] s1_data;
    logic [TAG_WIDTH-1:0]   s1_tag;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_data  <= '0;
            s1_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x    <= in_lead_sel ? ~in_data : in_data;
                s1_data <= in_data;
                s1_tag  <= in_tag;
            end
        end
    end

    // Trailing 1s in the padding stop the count from running past the real LSB.
    logic [PW-1:0] xp;
    always_comb begin
        xp = '1;
        xp[PW-1 -: INPUT_WIDTH] = s1_x;
    end

    // Heap-indexed halving tree: node k has children 2k (upper half) and 2k+1 (lower half).
    logic          zt [1:2*PW-1];
    logic [TW-1:0] ct [1:2*PW-1];

    for (genvar j = 0; j < PW; j++) begin : g_leaf
        assign zt[PW+j] = ~xp[PW-1-j];
        assign ct[PW+j] = '0;
    end

    for (genvar l = 1; l <= LOGP; l++) begin : g_lvl
        for (genvar i = 0; i < (PW >> l); i++) begin : g_node
            localparam int K = (PW >> l) + i;
            assign zt[K] = zt[2*K] & zt[2*K+1];
            assign ct[K] = zt[2*K] ? (TW'(1 << (l - 1)) | ct[2*K+1]) : ct[2*K];
        end
    end

    logic [TW-1:0]          cnt_full;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [INPUT_WIDTH-1:0] sh;

    assign cnt_full = zt[1] ? TW'(INPUT_WIDTH) : ct[1];
    assign cnt      = CNT_WIDTH'(cnt_full);

    always_comb begin
        sh = s1_data;
        for (int b = 0; b < CNT_WIDTH; b++) begin
            if (cnt[b]) sh = sh << (1 << b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_zero_nums <= '0;
            out_all_same  <= 1'b0;
            out_norm      <= '0;
            out_tag       <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_zero_nums <= cnt;
                out_all_same  <= (s1_x == '0);
                out_norm      <= sh;
                out_tag       <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_mul_norm_pipe.sv
// Directed and randomised scoreboard bench for mul_norm_pipe at a 24-bit mantissa.
module tb_mul_norm_pipe;

    localparam int W   = 24;
    localparam int TGW = 4;
    localparam int CW  = $clog2(W + 1);

    typedef struct packed {
        logic [CW-1:0]  cnt;
        logic           all;
        logic [W-1:0]   norm;
        logic [TGW-1:0] tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_lead_sel;
    logic [TGW-1:0] in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  out_zero_nums;
    logic           out_all_same;
    logic [W-1:0]   out_norm;
    logic [TGW-1:0] out_tag;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t drv_exp;
    exp_t snap;
    bit   stall_prev = 0;

    mul_norm_pipe #(.INPUT_WIDTH(W), .TAG_WIDTH(TGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lead_sel(in_lead_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_zero_nums(out_zero_nums), .out_all_same(out_all_same),
        .out_norm(out_norm), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d, input logic sel, input logic [TGW-1:0] t);
        exp_t e;
        int   n = 0;
        bit   run = 1;
        for (int i = W - 1; i >= 0; i--) begin
            if (run && d[i] == sel) n++;
            else run = 0;
        end
        e.cnt  = CW'(n);
        e.all  = (n == W);
        e.norm = (n >= W) ? '0 : (d << n);
        e.tag  = t;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic s, input logic [TGW-1:0] t);
        in_valid = v; in_data = d; in_lead_sel = s; in_tag = t;
        drv_exp = model(d, s, t);
    endtask

    task automatic drive_exp(input logic [W-1:0] d, input logic s, input logic [TGW-1:0] t, input exp_t e);
        in_valid = 1'b1; in_data = d; in_lead_sel = s; in_tag = t;
        drv_exp = e;
    endtask

    // Called between a negedge and the next posedge; evaluates the handshakes of the coming edge.
    task automatic tick();
        exp_t e;
        #1;
        if (stall_prev) begin
            chk("hold_cnt",  out_zero_nums, snap.cnt);
            chk("hold_all",  out_all_same,  snap.all);
            chk("hold_norm", out_norm,      snap.norm);
            chk("hold_tag",  out_tag,       snap.tag);
        end
        if (out_valid && out_ready) begin
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_cnt",  out_zero_nums, e.cnt);
                chk("out_all",  out_all_same,  e.all);
                chk("out_norm", out_norm,      e.norm);
                chk("out_tag",  out_tag,       e.tag);
            end
        end
        if (in_valid && in_ready) q.push_back(drv_exp);
        stall_prev = out_valid && !out_ready;
        snap = '{out_zero_nums, out_all_same, out_norm, out_tag};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] oh;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_norm", out_norm, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        drive_exp(24'h008000, 1'b0, 4'd5, '{5'd8,  1'b0, 24'h800000, 4'd5}); tick();
        drive_exp(24'h000000, 1'b0, 4'd6, '{5'd24, 1'b1, 24'h000000, 4'd6}); tick();
        drive_exp(24'h800000, 1'b0, 4'd7, '{5'd0,  1'b0, 24'h800000, 4'd7}); tick();
        drive_exp(24'hFFFA00, 1'b1, 4'd8, '{5'd13, 1'b0, 24'h400000, 4'd8}); tick();
        drive_exp(24'hFFFFFF, 1'b1, 4'd9, '{5'd24, 1'b1, 24'h000000, 4'd9}); tick();
        drive_exp(24'h000001, 1'b0, 4'd10, '{5'd23, 1'b0, 24'h800000, 4'd10}); tick();
        drain();

        // Backpressure: four back-to-back, then a 3-cycle stall with a fifth offered
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, W'(24'h000F00 >> k), 1'b0, TGW'(k));
            tick();
        end
        drive(1'b1, 24'h0000FF, 1'b0, 4'd5);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        drain();

        // Asynchronous reset with both stages full and a stall in progress
        drive(1'b1, 24'h0F0000, 1'b0, 4'd11); tick();
        drive(1'b1, 24'h00F000, 1'b0, 4'd12); tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_cnt", out_zero_nums, 0);
        chk("arst_all", out_all_same, 0);
        chk("arst_norm", out_norm, 0);
        chk("arst_tag", out_tag, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        stall_prev = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Latency: visible on the second edge after the input is presented
        drive(1'b1, 24'h004000, 1'b0, 4'd13); tick();
        in_valid = 1'b0;
        chk("lat_edge1", out_valid, 0);
        tick();
        chk("lat_edge2", out_valid, 1);
        drain();

        // One-hot sweep, inverted one-hot in lead-one mode, and zero
        for (int k = 0; k < W; k++) begin
            oh = '0;
            oh[k] = 1'b1;
            drive(1'b1, oh, 1'b0, TGW'(k)); tick();
            drive(1'b1, ~oh, 1'b1, TGW'(k + 1)); tick();
        end
        drive(1'b1, '0, 1'b0, 4'd3); tick();
        drive(1'b1, '0, 1'b1, 4'd4); tick();
        drain();

        // Random data, random lead_sel, random valid and ready
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] d;
            logic         s;
            s = 1'($urandom_range(0, 1));
            d = W'($urandom) >> $urandom_range(0, W);
            if (s) d = ~d;
            out_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 3) != 0), d, s, TGW'(n));
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
